// File: rtl/minigame_pkg.sv
// Shared types and default constants for the minigame round controller.
// Imported by the controller and any other game block that needs them.
package minigame_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARM,
      S_PLAY,
      S_RESULT,
      S_COOL
   } state_e;

   localparam int unsigned DEF_CLK_DIV        = 50000;
   localparam int unsigned DEF_TIMEOUT_TICKS  = 1000;
   localparam int unsigned DEF_COOLDOWN_TICKS = 100;
   localparam int unsigned DEF_SCORE_W        = 8;

endpackage

// File: rtl/minigame_if.sv
// Round-control bundle between a host/minigame and minigame_ctrl.
// The controller takes the slave view; the host side takes master.
interface minigame_if #(
   parameter int unsigned SCORE_W = 8
) ();

   logic               start;
   logic               abort;
   logic               mg_done;
   logic               mg_enable;
   logic               busy;
   logic               result_valid;
   logic               result_win;
   logic [SCORE_W-1:0] score;
   logic [SCORE_W-1:0] losses;

   modport master (
      output start, abort, mg_done,
      input  mg_enable, busy, result_valid,
      input  result_win, score, losses
   );

   modport slave (
      input  start, abort, mg_done,
      output mg_enable, busy, result_valid,
      output result_win, score, losses
   );

endinterface

// File: rtl/mg_tick_gen.sv
// Game-tick prescaler: counts 0..CLK_DIV-1, pulses tick at the top.
// clr restarts the count from zero on the next cycle.
module mg_tick_gen #(
   parameter int unsigned CLK_DIV = 50000
) (
   input  logic MCLK,
   input  logic RESET,
   input  logic clr,
   output logic tick
);

   localparam int unsigned W = $clog2(CLK_DIV);
   localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (clr || cnt_q == LAST) cnt_d = '0;
   end

   assign tick = (cnt_q == LAST);

   always_ff @(posedge MCLK or posedge RESET) begin
      if (RESET) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

endmodule

// File: rtl/minigame_ctrl.sv
// Minigame round controller: IDLE -> ARM -> PLAY -> RESULT -> COOLDOWN,
// with tick-based timeout/cooldown and saturating win/loss counters.
module minigame_ctrl
   import minigame_pkg::*;
#(
   parameter int unsigned CLK_DIV        = DEF_CLK_DIV,
   parameter int unsigned TIMEOUT_TICKS  = DEF_TIMEOUT_TICKS,
   parameter int unsigned COOLDOWN_TICKS = DEF_COOLDOWN_TICKS,
   parameter int unsigned SCORE_W        = DEF_SCORE_W
) (
   input  logic       MCLK,
   input  logic       RESET,
   minigame_if.slave  bus
);

   localparam int unsigned TMAX =
      (TIMEOUT_TICKS > COOLDOWN_TICKS) ? TIMEOUT_TICKS : COOLDOWN_TICKS;
   localparam int unsigned TW = $clog2(TMAX + 1);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_TICKS - 1);
   localparam logic [TW-1:0] C_LAST = TW'(COOLDOWN_TICKS - 1);
   localparam logic [SCORE_W-1:0] SAT = '1;

   state_e             state_q, state_d;
   logic [TW-1:0]      tcnt_q, tcnt_d;
   logic [SCORE_W-1:0] score_q, score_d;
   logic [SCORE_W-1:0] loss_q, loss_d;
   logic               win_q, win_d;
   logic               en_q, busy_q, rv_q;
   logic               tick, clr;

   mg_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
      .MCLK  (MCLK),
      .RESET (RESET),
      .clr   (clr),
      .tick  (tick)
   );

   always_comb begin
      state_d = state_q;
      win_d   = win_q;
      score_d = score_q;
      loss_d  = loss_q;
      tcnt_d  = tick ? tcnt_q + 1'b1 : tcnt_q;
      unique case (state_q)
         S_IDLE: if (bus.start) state_d = S_ARM;
         S_ARM:  state_d = bus.abort ? S_IDLE : S_PLAY;
         S_PLAY: begin
            // abort beats done, and done beats a same-cycle timeout
            if (bus.abort) begin
               state_d = S_IDLE;
            end else if (bus.mg_done) begin
               state_d = S_RESULT;
               win_d   = 1'b1;
               if (score_q != SAT) score_d = score_q + 1'b1;
            end else if (tick && tcnt_q == T_LAST) begin
               state_d = S_RESULT;
               win_d   = 1'b0;
               if (loss_q != SAT) loss_d = loss_q + 1'b1;
            end
         end
         S_RESULT: state_d = S_COOL;
         S_COOL: if (tick && tcnt_q == C_LAST) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      clr = (state_d == S_PLAY && state_q != S_PLAY) ||
            (state_d == S_COOL && state_q != S_COOL);
      if (clr) tcnt_d = '0;
   end

   always_ff @(posedge MCLK or posedge RESET) begin
      if (RESET) begin
         state_q <= S_IDLE;
         tcnt_q  <= '0;
         score_q <= '0;
         loss_q  <= '0;
         win_q   <= 1'b0;
         en_q    <= 1'b0;
         busy_q  <= 1'b0;
         rv_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         tcnt_q  <= tcnt_d;
         score_q <= score_d;
         loss_q  <= loss_d;
         win_q   <= win_d;
         en_q    <= (state_d == S_PLAY);
         busy_q  <= (state_d != S_IDLE);
         rv_q    <= (state_d == S_RESULT);
      end
   end

   assign bus.mg_enable    = en_q;
   assign bus.busy         = busy_q;
   assign bus.result_valid = rv_q;
   assign bus.result_win   = win_q;
   assign bus.score        = score_q;
   assign bus.losses       = loss_q;

endmodule

// File: tb/tb_minigame_ctrl.sv
// Directed bench for minigame_ctrl with CLK_DIV=4, TIMEOUT=3, COOLDOWN=2,
// SCORE_W=2; each scenario task carries its own expected values.
module tb_minigame_ctrl;

   logic MCLK;
   logic RESET;
   int   nvec;
   int   nerr;

   minigame_if #(.SCORE_W(2)) bus ();

   minigame_ctrl #(
      .CLK_DIV        (4),
      .TIMEOUT_TICKS  (3),
      .COOLDOWN_TICKS (2),
      .SCORE_W        (2)
   ) dut (
      .MCLK  (MCLK),
      .RESET (RESET),
      .bus   (bus)
   );

   initial MCLK = 1'b0;
   always #5 MCLK = ~MCLK;

   task automatic step(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge MCLK);
         #1;
      end
   endtask

   // start pulse: returns sampling in the first PLAY cycle
   task automatic start_round();
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      step();
   endtask

   task automatic test_reset();
      RESET = 1'b1;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      bus.mg_done = 1'b0;
      step(2);
      nvec++;
      if ({bus.mg_enable, bus.busy, bus.result_valid, bus.result_win,
           bus.score, bus.losses} !== 8'h00) begin
         nerr++;
         $display("FAIL reset_outputs: got en=%b busy=%b rv=%b win=%b score=%0d losses=%0d, want all 0",
                  bus.mg_enable, bus.busy, bus.result_valid, bus.result_win,
                  bus.score, bus.losses);
      end
      RESET = 1'b0;
      step();
   endtask

   task automatic test_win();
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      nvec++;
      if (bus.busy !== 1'b1 || bus.mg_enable !== 1'b0) begin
         nerr++;
         $display("FAIL win_arm: got busy=%b en=%b, want busy=1 en=0",
                  bus.busy, bus.mg_enable);
      end
      step();
      nvec++;
      if (bus.mg_enable !== 1'b1) begin
         nerr++;
         $display("FAIL win_enable_latency: got en=%b, want 1", bus.mg_enable);
      end
      step(5);
      bus.mg_done = 1'b1;
      step();
      bus.mg_done = 1'b0;
      nvec++;
      if (bus.result_valid !== 1'b1 || bus.result_win !== 1'b1 ||
          bus.score !== 2'd1 || bus.mg_enable !== 1'b0) begin
         nerr++;
         $display("FAIL win_result: got rv=%b win=%b score=%0d en=%b, want rv=1 win=1 score=1 en=0",
                  bus.result_valid, bus.result_win, bus.score, bus.mg_enable);
      end
      step();
      nvec++;
      if (bus.result_valid !== 1'b0 || bus.result_win !== 1'b1) begin
         nerr++;
         $display("FAIL win_pulse_width: got rv=%b win=%b, want rv=0 win=1",
                  bus.result_valid, bus.result_win);
      end
      step(7);
      nvec++;
      if (bus.busy !== 1'b1) begin
         nerr++;
         $display("FAIL win_cooldown_busy: got busy=%b, want 1", bus.busy);
      end
      step();
      nvec++;
      if (bus.busy !== 1'b0) begin
         nerr++;
         $display("FAIL win_cooldown_end: got busy=%b, want 0", bus.busy);
      end
   endtask

   task automatic test_timeout();
      int en_cnt;
      int rv_seen;
      logic win_seen;
      en_cnt = 0;
      rv_seen = 0;
      win_seen = 1'bx;
      RESET = 1'b1;
      step();
      RESET = 1'b0;
      step();
      start_round();
      for (int i = 0; i < 30 && rv_seen == 0; i++) begin
         if (bus.mg_enable === 1'b1) en_cnt++;
         if (bus.result_valid === 1'b1) begin
            rv_seen = 1;
            win_seen = bus.result_win;
         end else begin
            step();
         end
      end
      nvec++;
      if (rv_seen != 1 || en_cnt != 12) begin
         nerr++;
         $display("FAIL timeout_enable_len: got rv_seen=%0d en_cycles=%0d, want 1 and 12",
                  rv_seen, en_cnt);
      end
      nvec++;
      if (win_seen !== 1'b0 || bus.losses !== 2'd1 || bus.score !== 2'd0) begin
         nerr++;
         $display("FAIL timeout_result: got win=%b losses=%0d score=%0d, want win=0 losses=1 score=0",
                  win_seen, bus.losses, bus.score);
      end
      step(10);
   endtask

   task automatic test_tie();
      RESET = 1'b1;
      step();
      RESET = 1'b0;
      step();
      start_round();
      step(11);
      bus.mg_done = 1'b1;
      step();
      bus.mg_done = 1'b0;
      nvec++;
      if (bus.result_valid !== 1'b1 || bus.result_win !== 1'b1 ||
          bus.score !== 2'd1 || bus.losses !== 2'd0) begin
         nerr++;
         $display("FAIL tie_result: got rv=%b win=%b score=%0d losses=%0d, want rv=1 win=1 score=1 losses=0",
                  bus.result_valid, bus.result_win, bus.score, bus.losses);
      end
      step(10);
   endtask

   // runs with score=1, losses=0 left over from the tie round
   task automatic test_abort();
      int rv_cnt;
      rv_cnt = 0;
      start_round();
      step(3);
      bus.abort = 1'b1;
      bus.mg_done = 1'b1;
      step();
      bus.abort = 1'b0;
      bus.mg_done = 1'b0;
      nvec++;
      if (bus.busy !== 1'b0 || bus.mg_enable !== 1'b0 ||
          bus.result_valid !== 1'b0) begin
         nerr++;
         $display("FAIL abort_idle: got busy=%b en=%b rv=%b, want 0 0 0",
                  bus.busy, bus.mg_enable, bus.result_valid);
      end
      for (int i = 0; i < 6; i++) begin
         step();
         if (bus.result_valid === 1'b1) rv_cnt++;
      end
      nvec++;
      if (rv_cnt != 0 || bus.score !== 2'd1 || bus.losses !== 2'd0) begin
         nerr++;
         $display("FAIL abort_counters: got pulses=%0d score=%0d losses=%0d, want 0 1 0",
                  rv_cnt, bus.score, bus.losses);
      end
   endtask

   task automatic test_back_to_back();
      int rv_cnt;
      logic [1:0] seq [5];
      RESET = 1'b1;
      step();
      RESET = 1'b0;
      step();
      rv_cnt = 0;
      bus.start = 1'b1;
      bus.mg_done = 1'b1;
      for (int i = 0; i < 90; i++) begin
         step();
         if (bus.result_valid === 1'b1) begin
            if (rv_cnt < 5) seq[rv_cnt] = bus.score;
            rv_cnt++;
            if (rv_cnt == 5) bus.start = 1'b0;
         end
      end
      bus.mg_done = 1'b0;
      nvec++;
      if (rv_cnt != 5) begin
         nerr++;
         $display("FAIL sat_pulse_count: got %0d pulses, want 5", rv_cnt);
      end
      nvec++;
      if (rv_cnt >= 5 && (seq[0] !== 2'd1 || seq[1] !== 2'd2 ||
          seq[2] !== 2'd3 || seq[3] !== 2'd3 || seq[4] !== 2'd3)) begin
         nerr++;
         $display("FAIL sat_sequence: got %0d,%0d,%0d,%0d,%0d want 1,2,3,3,3",
                  seq[0], seq[1], seq[2], seq[3], seq[4]);
      end
   endtask

   // runs with score=3 left over from the saturation rounds
   task automatic test_async_reset();
      start_round();
      step(2);
      #2;
      RESET = 1'b1;
      #1;
      nvec++;
      if (bus.mg_enable !== 1'b0 || bus.busy !== 1'b0) begin
         nerr++;
         $display("FAIL async_reset_now: got en=%b busy=%b, want 0 0",
                  bus.mg_enable, bus.busy);
      end
      step();
      RESET = 1'b0;
      step();
      nvec++;
      if (bus.score !== 2'd0 || bus.losses !== 2'd0 ||
          bus.result_valid !== 1'b0) begin
         nerr++;
         $display("FAIL async_reset_clear: got score=%0d losses=%0d rv=%b, want 0 0 0",
                  bus.score, bus.losses, bus.result_valid);
      end
      start_round();
      step();
      bus.mg_done = 1'b1;
      step();
      bus.mg_done = 1'b0;
      nvec++;
      if (bus.result_valid !== 1'b1 || bus.result_win !== 1'b1 ||
          bus.score !== 2'd1) begin
         nerr++;
         $display("FAIL async_reset_fresh: got rv=%b win=%b score=%0d, want 1 1 1",
                  bus.result_valid, bus.result_win, bus.score);
      end
   endtask

   initial begin
      nvec = 0;
      nerr = 0;
      RESET = 1'b1;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      bus.mg_done = 1'b0;
      test_reset();
      test_win();
      test_timeout();
      test_tie();
      test_abort();
      test_back_to_back();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
